seg7_scan_ctrl: RTL and testbench

- Display back-end that consumes the 32-bit result word produced by the single-cycle core (register-file debug tap or ALU result).
- Captures the word on a load strobe and shows it as 8 hex digits on the board's multiplexed common-anode 7-segment display.
- Replaces the ad-hoc toggle and decoder logic in the top level with a tear-free, frame-synchronous scanner.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_scan_ctrl_hex_to_seg7.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment lookup for the 7-segment scanner.
// Segment encoding is {a,b,c,d,e,f,g} with g as the LSB, active-low
// (common-anode display), so a 0 bit lights the segment.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b1100000;
      4'hC:    pat = 7'b0110001;
      4'hD:    pat = 7'b1000010;
      4'hE:    pat = 7'b0110000;
      default: pat = 7'b0111000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment pattern.
//   nib : 4-bit hex value
//   seg : {a,b,c,d,e,f,g}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_seg(nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Frame-synchronous multiplexed 7-segment scanner for a 32-bit word.
// A loaded word is staged and only committed to the displayed (shadow) word
// at the end of a full scan frame, so one frame never mixes two words.
//   clk      : system clock
//   rst      : asynchronous reset, active-low
//   value_in : word to display, captured when load=1
//   load     : single-cycle capture strobe
//   blank_lz : 1 = blank leading-zero digits (digit 0 always shown)
//   an       : anode enables, active-low, digit k on an[7-k]
//   seg      : cathodes {a..g}, active-low
//   pending  : a staged word is waiting for the frame boundary
//   is_zero  : displayed word is zero
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        pending,
  output logic        is_zero
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
  logic [31:0]      staging_q, staging_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             is_zero_q, is_zero_d;

  logic       tick;
  logic       frame_end;
  logic [3:0] nibble;
  logic       upper_nz;
  logic [6:0] hex_pat;

  // Slot divider and digit index
  always_comb begin
    tick        = (div_cnt_q == DIV_LAST);
    frame_end   = tick && (digit_idx_q == IDX_LAST);
    div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
    digit_idx_d = digit_idx_q;
    if (tick) begin
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
    end
  end

  // Load handshake: a load landing on the frame boundary bypasses staging,
  // otherwise the last staged word is committed at the boundary.
  always_comb begin
    staging_d = load ? value_in : staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_d = value_in;
      end else if (pending_q) begin
        shadow_d = staging_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Digit select, anode decode and leading-zero detection. upper_nz is set
  // when any nibble at or above the current digit is non-zero.
  always_comb begin
    nibble   = 4'h0;
    upper_nz = 1'b0;
    an_d     = AN_OFF;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (digit_idx_q == IDX_W'(j)) begin
        nibble     = shadow_q[4*j +: 4];
        an_d[7-j]  = 1'b0;
      end
      if ((IDX_W'(j) >= digit_idx_q) && (shadow_q[4*j +: 4] != 4'h0)) begin
        upper_nz = 1'b1;
      end
    end
    seg_d     = (blank_lz && (digit_idx_q != '0) && !upper_nz) ? SEG_BLANK : hex_pat;
    is_zero_d = (shadow_q == '0);
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nib (nibble),
    .seg (hex_pat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      staging_q   <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      is_zero_q   <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      staging_q   <= staging_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      is_zero_q   <= is_zero_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign pending = pending_q;
  assign is_zero = is_zero_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with a 4-cycle slot and 8 digits (32-cycle frame).
// The reference model tracks the position in the scan timeline as a plain
// edge count since reset and derives slot/frame boundaries arithmetically.
module tb_seg7_scan_ctrl;

  localparam int R     = 4;
  localparam int N     = 8;
  localparam int FRAME = R * N;

  logic        clk;
  logic        rst;
  logic [31:0] value_in;
  logic        load;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        pending;
  logic        is_zero;

  seg7_scan_ctrl #(.REFRESH_DIV(R), .NUM_DIGITS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .load     (load),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .pending  (pending),
    .is_zero  (is_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0]  seg_tbl [16];
  logic [31:0] m_shadow, m_staging;
  logic        m_pending;
  int unsigned m_pos;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_zero;
  logic        blz_cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_shadow  = '0;
    m_staging = '0;
    m_pending = 1'b0;
    m_pos     = 0;
  endtask

  // Called right after a rising edge, with the inputs that edge sampled.
  task automatic model_step();
    int  digit;
    logic [31:0] upper;
    logic frame_end;
    digit    = (m_pos / R) % N;
    upper    = m_shadow >> (4 * digit);
    exp_an   = 8'hFF;
    exp_an[7-digit] = 1'b0;
    if (blank_lz && digit != 0 && upper == 0) exp_seg = 7'h7F;
    else exp_seg = seg_tbl[upper[3:0]];
    exp_zero = (m_shadow == 0);
    frame_end = ((m_pos % FRAME) == FRAME - 1);
    if (frame_end) begin
      if (load) m_shadow = value_in;
      else if (m_pending) m_shadow = m_staging;
      m_pending = 1'b0;
    end else if (load) begin
      m_pending = 1'b1;
    end
    if (load) m_staging = value_in;
    m_pos++;
  endtask

  // Caller is at a falling edge; drives inputs, crosses one rising edge and
  // checks the outputs at the following falling edge.
  task automatic cycle(input logic ld, input logic [31:0] v, input logic blz);
    load     = ld;
    value_in = v;
    blank_lz = blz;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("an", {24'h0, an}, {24'h0, exp_an});
    check("seg", {25'h0, seg}, {25'h0, exp_seg});
    check("pending", {31'h0, pending}, {31'h0, m_pending});
    check("is_zero", {31'h0, is_zero}, {31'h0, exp_zero});
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, blz_cur);
  endtask

  task automatic advance_to(input int target);
    for (int i = 0; i < 2 * FRAME && (m_pos % FRAME) != target; i++)
      cycle(1'b0, 32'h0, blz_cur);
    check("frame_align", m_pos % FRAME, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, {24'h0, an}, 32'hFF);
    check({tag, "_seg"}, {25'h0, seg}, 32'h7F);
    check({tag, "_pending"}, {31'h0, pending}, 32'h0);
    check({tag, "_is_zero"}, {31'h0, is_zero}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_tbl[0]  = 7'b0000001; seg_tbl[1]  = 7'b1001111;
    seg_tbl[2]  = 7'b0010010; seg_tbl[3]  = 7'b0000110;
    seg_tbl[4]  = 7'b1001100; seg_tbl[5]  = 7'b0100100;
    seg_tbl[6]  = 7'b0100000; seg_tbl[7]  = 7'b0001111;
    seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0000100;
    seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b1100000;
    seg_tbl[12] = 7'b0110001; seg_tbl[13] = 7'b1000010;
    seg_tbl[14] = 7'b0110000; seg_tbl[15] = 7'b0111000;

    rst      = 1'b0;
    load     = 1'b0;
    value_in = '0;
    blank_lz = 1'b0;
    blz_cur  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    model_reset();

    // Idle scan of zero
    idle(40);

    // Load early in frame, held pending until the boundary
    advance_to(2);
    cycle(1'b1, 32'h1234ABCD, blz_cur);
    check("pending_after_load", {31'h0, pending}, 32'h1);
    idle(2 * FRAME);

    // Last of two loads in one frame wins
    advance_to(5);
    cycle(1'b1, 32'h5, blz_cur);
    idle(3);
    cycle(1'b1, 32'h9, blz_cur);
    idle(2 * FRAME);

    // Leading-zero blanking, then blanking off
    blz_cur = 1'b1;
    advance_to(1);
    cycle(1'b1, 32'h50, blz_cur);
    idle(2 * FRAME);
    blz_cur = 1'b0;
    idle(FRAME);

    // Load exactly on the frame boundary bypasses staging
    advance_to(FRAME - 1);
    cycle(1'b1, 32'hFFFFFFFF, blz_cur);
    check("bypass_pending", {31'h0, pending}, 32'h0);
    idle(FRAME + 2);

    // Randomized loads and blanking
    for (int i = 0; i < 500; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 2))
        0:       v = $urandom;
        1:       v = 32'($urandom_range(0, 255)) << (4 * $urandom_range(0, 6));
        default: v = 32'($urandom_range(0, 15));
      endcase
      blz_cur = ($urandom_range(0, 15) == 0) ? ~blz_cur : blz_cur;
      cycle($urandom_range(0, 9) == 0, v, blz_cur);
    end

    // Mid-frame reset with a word pending
    blz_cur = 1'b0;
    advance_to(10);
    cycle(1'b1, 32'hDEADBEEF, blz_cur);
    idle(3);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    rst = 1'b1;
    model_reset();
    idle(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
